// File: rtl/irrigation_scheduler_pkg.sv
// Shared encodings for the irrigation scheduler: FSM states and the
// recorded reason a grant ended.
package irrigation_scheduler_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_OPEN  = 2'd1;
    localparam logic [1:0] S_WATER = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic CAUSE_DONE  = 1'b0;
    localparam logic CAUSE_ABORT = 1'b1;

endpackage

// File: rtl/irrigation_scheduler_tick_timer.sv
// Tick-driven duration counter: counts tick strobes since the last clear and
// flags the tick that completes the requested duration.
module tick_timer #(
    parameter int TIMER_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               tick,
    input  logic [TIMER_W-1:0] duration,
    output logic [TIMER_W-1:0] count,
    output logic               expire
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick) begin
            count <= count + 1'b1;
        end
    end

    // Expiry coincides with the tick itself, so the owner leaves on that edge.
    assign expire = tick && (count == duration - 1'b1);

endmodule

// File: rtl/irrigation_scheduler.sv
// Round-robin pump sharing across irrigation zones: open valve, settle,
// water, drain, close. All outputs are registers with async reset.
module irrigation_scheduler
    import irrigation_scheduler_pkg::*;
#(
    parameter int ZONES        = 4,
    parameter int ZONE_W       = 2,
    parameter int SETTLE_TICKS = 2,
    parameter int WATER_TICKS  = 5,
    parameter int TIMER_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tick,
    input  logic              enable,
    input  logic              tank_low,
    input  logic [ZONES-1:0]  request,
    output logic [ZONES-1:0]  valve,
    output logic              pump,
    output logic [ZONE_W-1:0] zone,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [1:0]        dbg_state
);

    localparam logic [TIMER_W-1:0] SETTLE_D = TIMER_W'(SETTLE_TICKS);
    localparam logic [TIMER_W-1:0] WATER_D  = TIMER_W'(WATER_TICKS);
    localparam logic [ZONES-1:0]   ONE      = {{(ZONES-1){1'b0}}, 1'b1};

    logic [1:0]         state;
    logic [1:0]         next_state;
    logic [ZONE_W-1:0]  ptr;
    logic [ZONE_W-1:0]  pick;
    logic [ZONE_W-1:0]  ptr_next;
    logic               cause;
    logic               abort_req;
    logic               drop_req;
    logic               timer_clear;
    logic [TIMER_W-1:0] duration;
    logic [TIMER_W-1:0] timer;
    logic               expire;

    // First set request at or after start, wrapping; start itself if none.
    function automatic logic [ZONE_W-1:0] rr_pick(input logic [ZONES-1:0] req,
                                                  input logic [ZONE_W-1:0] start);
        logic [ZONE_W-1:0] sel;
        logic [ZONE_W-1:0] idx;
        logic              found;
        sel   = start;
        found = 1'b0;
        for (int i = 0; i < ZONES; i++) begin
            idx = ZONE_W'((int'(start) + i) % ZONES);
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign pick      = rr_pick(request, ptr);
    assign ptr_next  = (zone == ZONE_W'(ZONES - 1)) ? '0 : zone + 1'b1;
    assign abort_req = tank_low || !enable;
    assign drop_req  = !request[zone];
    assign dbg_state = state;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (enable && !tank_low && (|request)) next_state = S_OPEN;
            S_OPEN:  if (abort_req || drop_req) next_state = S_DRAIN;
                     else if (expire)           next_state = S_WATER;
            S_WATER: if (abort_req || drop_req || expire) next_state = S_DRAIN;
            S_DRAIN: if (expire) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign timer_clear = (state == S_IDLE) || (next_state != state);
    assign duration    = (state == S_WATER) ? WATER_D : SETTLE_D;

    tick_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (timer_clear),
        .tick     (tick),
        .duration (duration),
        .count    (timer),
        .expire   (expire)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            valve   <= '0;
            pump    <= 1'b0;
            zone    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
            ptr     <= '0;
            cause   <= CAUSE_DONE;
        end else begin
            state   <= next_state;
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (next_state == S_OPEN) begin
                        zone  <= pick;
                        valve <= ONE << pick;
                        busy  <= 1'b1;
                    end
                end
                S_OPEN: begin
                    if (next_state == S_DRAIN) begin
                        cause <= abort_req ? CAUSE_ABORT : CAUSE_DONE;
                    end else if (next_state == S_WATER) begin
                        pump <= 1'b1;
                    end
                end
                S_WATER: begin
                    // Timeout and request drop both count as a normal finish.
                    if (next_state == S_DRAIN) begin
                        pump  <= 1'b0;
                        cause <= abort_req ? CAUSE_ABORT : CAUSE_DONE;
                    end
                end
                S_DRAIN: begin
                    if (next_state == S_IDLE) begin
                        valve   <= '0;
                        busy    <= 1'b0;
                        ptr     <= ptr_next;
                        done    <= (cause == CAUSE_DONE);
                        aborted <= (cause == CAUSE_ABORT);
                    end
                end
                default: pump <= 1'b0;
            endcase
        end
    end

    // Timer width is sized for durations; only the low bits matter here.
    logic unused_timer;
    assign unused_timer = ^timer;

endmodule
